demux_rr_sched: RTL and testbench



---
 rtl/demux_rr_sched.sv | 179 +++++++++++++++++
 tb/tb_demux_rr_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler feeding a 1x8 demux: grants BURST items per
// enabled channel, holds one item, honours per-channel backpressure.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en, chan_mask   global enable, channels taking part in rotation
//   in_data/valid/ready  input stream (in_ready is combinational)
//   out_ready[7:0]  per-consumer ready; only bit sel is used
//   sel, dmx_e, dmx_y  demux select / enable / data
//   out_valid[7:0]  one-hot of sel while an item is held
//   busy            scheduler not idle
//
// Optional feature: define DEMUX_RR_SCHED_TIMEOUT_EN to close a burst
// early after TIMEOUT consecutive cycles without an accept.

module demux_rr_sched #(
  parameter int WIDTH   = 1,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       chan_mask,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       out_ready,
  output logic [2:0]       sel,
  output logic             dmx_e,
  output logic [WIDTH-1:0] dmx_y,
  output logic [7:0]       out_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             hold_v_q, hold_v_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  logic       any_en;
  logic       drain;
  logic       accept;
  logic       burst_end;
  logic       timeout;
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;

  assign any_en = |chan_mask;
  assign drain  = hold_v_q && out_ready[sel_q];
  assign accept = in_valid && in_ready;

  // Last accept of the burst: count before this accept is BURST-1.
  assign burst_end = accept && (cnt_q + 4'd1 == 4'(BURST));

`ifdef DEMUX_RR_SCHED_TIMEOUT_EN
  logic [7:0] idle_q, idle_d;

  // Counts consecutive XFER cycles with no accept; zero outside XFER
  // so it is already clear on every entry to XFER.
  always_comb begin
    idle_d = 8'd0;
    if (state_q == XFER && !accept) begin
      idle_d = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
    end
  end

  assign timeout = (state_q == XFER) && !accept &&
                   (idle_d == 8'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) idle_q <= 8'd0;
    else     idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Scan from last+1 to last+8 (wrapping); last itself comes up last,
  // so a lone enabled channel is re-granted.
  always_comb begin
    win   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + 3'(i);
      if (!found && chan_mask[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en && any_en) state_d = SEEK;
      end
      SEEK: begin
        state_d = (en && any_en) ? XFER : IDLE;
      end
      XFER: begin
        if (!en || !chan_mask[sel_q]) state_d = DRAIN;
        else if (burst_end)           state_d = DRAIN;
        else if (timeout)             state_d = DRAIN;
      end
      DRAIN: begin
        // Leaving on the draining cycle still guarantees an empty
        // hold by the time SEEK updates sel.
        if (!hold_v_q || drain) begin
          state_d = (en && any_en) ? SEEK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == XFER) && en && chan_mask[sel_q] &&
                (!hold_v_q || out_ready[sel_q]);
    busy      = (state_q != IDLE);
    sel       = sel_q;
    dmx_e     = hold_v_q;
    dmx_y     = hold_q;
    out_valid = hold_v_q ? (8'd1 << sel_q) : 8'd0;
  end

  always_comb begin
    sel_d    = sel_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    if (drain) hold_v_d = 1'b0;
    if (accept) begin
      hold_v_d = 1'b1;
      hold_d   = in_data;
      cnt_d    = (cnt_q == 4'(BURST)) ? cnt_q : cnt_q + 4'd1;
    end
    if (state_q == SEEK && en && any_en) begin
      sel_d  = win;
      last_d = win;
      cnt_d  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 3'd0;
      last_q   <= 3'd7;
      cnt_q    <= 4'd0;
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      sel_q    <= sel_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: directed scenarios plus random traffic,
// checked against a grant-order scoreboard.

module tb_demux_rr_sched;

  localparam int W  = 8;
  localparam int B  = 4;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [7:0]   chan_mask;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_ready;
  logic [2:0]   sel;
  logic         dmx_e;
  logic [W-1:0] dmx_y;
  logic [7:0]   out_valid;
  logic         busy;

  always #5 clk = ~clk;

  demux_rr_sched #(
    .WIDTH(W), .BURST(B), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .chan_mask(chan_mask),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .sel(sel), .dmx_e(dmx_e),
    .dmx_y(dmx_y), .out_valid(out_valid), .busy(busy)
  );

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] d;
  } item_t;

  int         n_chk = 0;
  int         n_err = 0;
  item_t      sb[$];
  logic [2:0] m_last;
  int         m_cnt;
  bit         m_open;
  bit         acc_seen;
  int         dlv;
  logic [2:0] dlv_ch;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] next_chan(logic [2:0] last,
                                           logic [7:0] m);
    for (int i = 1; i <= 8; i++) begin
      if (m[(int'(last) + i) % 8]) return 3'((int'(last) + i) % 8);
    end
    return last;
  endfunction

  task automatic model_reset();
    m_last = 3'd7;
    m_open = 1'b0;
    m_cnt  = 0;
    sb.delete();
  endtask

  // One clock: observe at negedge, return 1 time unit after posedge.
  task automatic cyc();
    item_t e;
    @(negedge clk);
    acc_seen = 1'b0;
    if (dmx_e && out_ready[sel]) begin
      dlv++;
      dlv_ch = sel;
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dlv_chan", 32'(sel), 32'(e.ch));
        chk("dlv_data", 32'(dmx_y), 32'(e.d));
      end
    end
    chk("out_valid", 32'(out_valid),
        dmx_e ? (32'd1 << sel) : 32'd0);
    if (in_valid && in_ready) begin
      if (!m_open) begin
        m_last = next_chan(m_last, chan_mask);
        m_open = 1'b1;
        m_cnt  = 0;
      end
      sb.push_back('{m_last, in_data});
      m_cnt++;
      if (m_cnt == B) m_open = 1'b0;
      acc_seen = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    chan_mask = 8'h00;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    dlv = 0;
  endtask

  task automatic flush();
    in_valid  = 1'b0;
    out_ready = 8'hFF;
    for (int i = 0; i < 60 && sb.size() > 0; i++) cyc();
    chk("flush_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int         d;
    int         k;
    logic [7:0] held;
    logic [2:0] g[$];

    // Reset values
    do_reset();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_dmx_e", 32'(dmx_e), 32'd0);
    chk("rst_dmx_y", 32'(dmx_y), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Silent source on channel 0 of mask 03
    chan_mask = 8'h03;
    en        = 1'b1;
    out_ready = 8'hFF;
    repeat (25) cyc();
`ifdef DEMUX_RR_SCHED_TIMEOUT_EN
    chk("timeout_sel", 32'(sel), 32'd1);
`else
    chk("timeout_sel", 32'(sel), 32'd0);
`endif
    chk("timeout_busy", 32'(busy), 32'd1);

    // Full rotation, counting data
    do_reset();
    chan_mask = 8'hFF;
    en        = 1'b1;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    d = 0;
    for (int i = 0; i < 80; i++) begin
      in_data = W'(d);
      cyc();
      if (acc_seen) d++;
    end
    chk("rot_items", 32'(d >= 36), 32'd1);
    flush();

    // Sparse mask, then drop channel 5 while 2 is active
    do_reset();
    chan_mask = 8'b1010_0100;
    en        = 1'b1;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    d = 0;
    g.delete();
    for (int i = 0; i < 45; i++) begin
      in_data = W'(d);
      cyc();
      if (acc_seen) d++;
      if (dmx_e && (g.size() == 0 || sel != g[$])) g.push_back(sel);
    end
    chk("grant_cnt", 32'(g.size() >= 4), 32'd1);
    if (g.size() >= 4) begin
      chk("grant0", 32'(g[0]), 32'd2);
      chk("grant1", 32'(g[1]), 32'd5);
      chk("grant2", 32'(g[2]), 32'd7);
      chk("grant3", 32'(g[3]), 32'd2);
    end
    k = 0;
    while (k < 60 && !(sel == 3'd2 && dmx_e)) begin
      in_data = W'(d);
      cyc();
      if (acc_seen) d++;
      k++;
    end
    chk("wait_ch2", 32'(sel), 32'd2);
    chan_mask = 8'b1000_0100;
    k = 0;
    while (k < 30 && sel == 3'd2) begin
      in_data = W'(d);
      cyc();
      if (acc_seen) d++;
      k++;
    end
    chk("skip_ch5", 32'(sel), 32'd7);
    flush();

    // Backpressure on channel 0
    do_reset();
    chan_mask = 8'hFF;
    en        = 1'b1;
    in_valid  = 1'b1;
    d = 100;
    k = 0;
    acc_seen = 1'b0;
    while (k < 10 && !acc_seen) begin
      in_data = W'(d);
      cyc();
      if (acc_seen) d++;
      k++;
    end
    chk("bp_first_acc", 32'(acc_seen), 32'd1);
    held = 8'(d - 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_dmx_e", 32'(dmx_e), 32'd1);
      chk("bp_dmx_y", 32'(dmx_y), 32'(held));
      chk("bp_out_valid", 32'(out_valid), 32'h01);
      in_data = W'(d);
      cyc();
      if (acc_seen) d++;
    end
    out_ready = 8'hFF;
    #1;
    chk("bp_resume_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < B - 1; i++) begin
      in_data = W'(d);
      cyc();
      chk("bp_stream", 32'(acc_seen), 32'd1);
      if (acc_seen) d++;
    end
    flush();

    // en drops after two accepts
    do_reset();
    chan_mask = 8'hFF;
    en        = 1'b1;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    d = 0;
    k = 0;
    while (k < 20 && d < 2) begin
      in_data = W'(d);
      cyc();
      if (acc_seen) d++;
      k++;
    end
    chk("en_two_acc", 32'(d), 32'd2);
    en = 1'b0;
    #1;
    chk("en_in_ready", 32'(in_ready), 32'd0);
    m_open   = 1'b0;
    in_valid = 1'b0;
    k = 0;
    while (k < 10 && busy) begin
      cyc();
      k++;
    end
    chk("en_busy", 32'(busy), 32'd0);
    chk("en_sel", 32'(sel), 32'd0);
    chk("en_dmx_e", 32'(dmx_e), 32'd0);
    chk("en_sb", 32'(sb.size()), 32'd0);

    // Reset with hold full
    do_reset();
    chan_mask = 8'hFF;
    en        = 1'b1;
    in_valid  = 1'b1;
    chan_mask = 8'b0011_0000;
    k = 0;
    acc_seen = 1'b0;
    while (k < 10 && !acc_seen) begin
      in_data = W'(8'h5A);
      cyc();
      k++;
    end
    chk("rst_mid_full", 32'(dmx_e), 32'd1);
    chk("rst_mid_sel", 32'(sel), 32'd4);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_dmx_e", 32'(dmx_e), 32'd0);
    chk("rst_mid_ovld", 32'(out_valid), 32'd0);
    chk("rst_mid_sel0", 32'(sel), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    model_reset();
    dlv       = 0;
    chan_mask = 8'hFF;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    k = 0;
    while (k < 10 && dlv == 0) begin
      in_data = W'(k);
      cyc();
      k++;
    end
    chk("rst_first_ch", 32'(dlv_ch), 32'd0);
    flush();

    // Random traffic with a fixed random mask per round
    for (int r = 0; r < 4; r++) begin
      do_reset();
      chan_mask = 8'($urandom_range(1, 255));
      en        = 1'b1;
      for (int i = 0; i < 500; i++) begin
        in_valid  = ($urandom % 8) != 0;
        in_data   = W'($urandom);
        out_ready = 8'($urandom | $urandom | $urandom);
        cyc();
      end
      flush();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
